// File: rtl/mv_pkg.sv
// -----------------------------------------------------------------------------
// mv_pkg
// Shared definitions for the matrix-vector driver:
//   - mv_state_e     : driver FSM state encoding
//   - MV_* constants : default parameter values for the driver
//   - mv_coef()      : 6x6 matrix coefficient (16*i + j + 1) used by the
//                      behavioural multiplier model
// -----------------------------------------------------------------------------
package mv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_CAPTURE = 2'd2
  } mv_state_e;

  localparam int MV_FIFO_DEPTH  = 4;
  localparam int MV_HOLD_CYCLES = 3;
  localparam int MV_RES_LAT     = 3;
  localparam int MV_DATA_W      = 6;
  localparam int MV_VEC_W       = 8;

  // Coefficient of row i, column j of the 6x6 matrix.
  function automatic int mv_coef(input int i, input int j);
    return 16 * i + j + 1;
  endfunction

endpackage

// File: rtl/mv_sync_fifo.sv
// -----------------------------------------------------------------------------
// mv_sync_fifo
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and pops
// from an empty FIFO are ignored. Pointers wrap modulo DEPTH (power of two).
// Ports:
//   i_clk, i_rst   clock, async active-high reset (pointers/count only)
//   i_push, i_data write request and data
//   i_pop          read request; o_data shows the head word combinationally
//   o_full/o_empty occupancy flags
//   o_count        current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mv_sync_fifo
  import mv_pkg::*;
#(
  parameter int DEPTH = MV_FIFO_DEPTH,
  parameter int WIDTH = MV_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset: reads are gated by the count, so stale
  // contents are never observed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mv_vec_driver.sv
// -----------------------------------------------------------------------------
// mv_vec_driver
// Queues 6-bit words and presents each one to a matrix-vector multiplier as an
// 8-bit vector {data, 1'b0, toggle}. Each word is held for HOLD_CYCLES edges
// (counted from its launch edge); the multiplier result is captured RES_LAT
// edges after launch and reported with a one-cycle o_res_valid pulse.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_in_valid/i_in_data producer handshake, o_in_ready = FIFO not full
//   o_vector            registered word to the multiplier, [0] toggles per launch
//   i_result_in         multiplier result bus
//   o_res_valid         one-cycle capture pulse, o_res_data holds last capture
//   o_busy              FSM not idle
//   o_fifo_count        FIFO occupancy
// -----------------------------------------------------------------------------
module mv_vec_driver
  import mv_pkg::*;
#(
  parameter int FIFO_DEPTH  = MV_FIFO_DEPTH,
  parameter int HOLD_CYCLES = MV_HOLD_CYCLES,
  parameter int RES_LAT     = MV_RES_LAT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_in_valid,
  input  logic [5:0]                    i_in_data,
  output logic                          o_in_ready,
  output logic [7:0]                    o_vector,
  input  logic [5:0]                    i_result_in,
  output logic                          o_res_valid,
  output logic [5:0]                    o_res_data,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  // Counter only needs to reach HOLD_CYCLES.
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  mv_state_e       r_state;
  mv_state_e       w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [7:0]      r_vector;
  logic            r_res_valid;
  logic [5:0]      r_res_data;

  logic            w_launch;
  logic            w_capture;
  logic            w_hold_done;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [5:0]      w_fifo_data;

  mv_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_in_valid),
    .i_data  (i_in_data),
    .i_pop   (w_launch),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  // r_cnt is the number of edges already spent on the current word
  // (the launch edge counts as 1), so this edge is launch + r_cnt.
  assign w_hold_done = (r_cnt >= CW'(HOLD_CYCLES));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_launch   = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_launch = 1'b1;
      end
      ST_HOLD: begin
        if (r_cnt == CW'(RES_LAT - 1)) begin
          w_state_nx = ST_CAPTURE;
          w_cnt_nx   = r_cnt + CW'(1);
        end else if (w_hold_done) begin
          // Only reachable after the capture, while waiting out the hold.
          if (!w_fifo_empty) begin
            w_launch = 1'b1;
          end else begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        if (w_hold_done) begin
          if (!w_fifo_empty) begin
            w_launch = 1'b1;
          end else begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
          end
        end else begin
          // Result taken before the hold expires: keep the word on the bus.
          w_state_nx = ST_HOLD;
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    if (w_launch) begin
      w_state_nx = ST_HOLD;
      w_cnt_nx   = CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_vector    <= 8'h00;
      r_res_valid <= 1'b0;
      r_res_data  <= 6'h00;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_res_valid <= w_capture;
      if (w_capture) r_res_data <= i_result_in;
      // Toggle flips only on a launch, so an empty FIFO leaves the bus frozen.
      if (w_launch)  r_vector   <= {w_fifo_data, 1'b0, ~r_vector[0]};
    end
  end

  assign o_in_ready  = !w_fifo_full;
  assign o_vector    = r_vector;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mv_vec_driver.sv
module tb_mv_vec_driver;
  import mv_pkg::*;

  localparam int DEPTH = MV_FIFO_DEPTH;
  localparam int HOLD  = MV_HOLD_CYCLES;
  localparam int RLAT  = MV_RES_LAT;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [5:0]      in_data;
  logic            in_ready;
  logic [7:0]      vector;
  logic [5:0]      result_in;
  logic            res_valid;
  logic [5:0]      res_data;
  logic            busy;
  logic [CNTW-1:0] fifo_count;

  int tests = 0;
  int fails = 0;

  mv_vec_driver #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .RES_LAT(RLAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_vector(vector), .i_result_in(result_in),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_busy(busy),
    .o_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Multiplier model: row i sums coefficient-derived weights over the set
  // bits of the word and returns the parity of the sum.
  function automatic logic [5:0] mv_model(input logic [5:0] d);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      int acc;
      acc = 0;
      for (int j = 0; j < 6; j++)
        if (d[j]) acc += (mv_coef(i, j) >> 4) + 1;
      r[i] = acc[0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loopback multiplier: the result only becomes correct once the vector has
  // been stable for RES_LAT edges, so an early capture returns wrong data.
  logic [7:0] mul_prev = 8'h00;
  int         mul_age  = 15;
  always @(negedge clk) begin
    if (vector !== mul_prev) begin
      mul_prev = vector;
      mul_age  = 1;
    end else if (mul_age < 15) begin
      mul_age++;
    end
  end
  assign result_in = (mul_age >= RLAT) ? mv_model(vector[7:2]) : ~mv_model(vector[7:2]);

  // Scoreboard state
  int         cyc = 0;
  int         acc_total = 0;
  int         rv_count = 0;
  logic [5:0] acc_q[$];
  logic [5:0] fl_q[$];
  int         fl_cyc[$];
  int         launch_cyc_q[$];
  logic [7:0] prev_vec = 8'h00;
  int         last_launch = -1;
  logic       prev_rv = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) begin
      acc_q.push_back(in_data);
      acc_total++;
    end
  end

  always @(negedge clk) begin
    logic exp_t;
    if (rst) begin
      acc_q.delete();
      fl_q.delete();
      fl_cyc.delete();
      prev_vec    = 8'h00;
      last_launch = -1;
      prev_rv     = 1'b0;
    end else begin
      if (vector !== prev_vec) begin
        exp_t = ~prev_vec[0];
        if (last_launch >= 0) chk("launch_spacing", (cyc - last_launch) >= HOLD, 1'b1);
        chk("toggle", vector[0], exp_t);
        chk("vec_bit1", vector[1], 1'b0);
        chk("launch_has_word", acc_q.size() > 0, 1'b1);
        if (acc_q.size() > 0) chk("launch_order", vector[7:2], acc_q.pop_front());
        fl_q.push_back(vector[7:2]);
        fl_cyc.push_back(cyc);
        launch_cyc_q.push_back(cyc);
        last_launch = cyc;
        prev_vec    = vector;
      end
      if (res_valid) begin
        chk("rv_single", prev_rv, 1'b0);
        chk("res_has_word", fl_q.size() > 0, 1'b1);
        if (fl_q.size() > 0) begin
          chk("res_data", res_data, mv_model(fl_q.pop_front()));
          chk("res_latency", cyc - fl_cyc.pop_front(), RLAT);
        end
        rv_count++;
      end
      prev_rv = res_valid;
      chk("fifo_count", fifo_count, acc_q.size());
      chk("in_ready", in_ready, fifo_count < DEPTH);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic tog;

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || fifo_count != 0) && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // Push one word into an idle driver and follow it through launch and capture.
  task automatic send_one(input logic [5:0] d, input logic [5:0] exp_res, input string tag);
    int k, n0;
    step(); in_valid = 1'b1; in_data = d;
    step(); in_valid = 1'b0;
    chk({tag, "_cnt"}, fifo_count, 1);
    step();
    tog = ~tog;
    chk({tag, "_vec"}, vector, {d, 1'b0, tog});
    chk({tag, "_busy"}, busy, 1'b1);
    n0 = rv_count;
    k  = 0;
    while (rv_count == n0 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, k, RLAT);
    chk({tag, "_res"}, res_data, exp_res);
    step();
    chk({tag, "_rv_low"}, res_valid, 1'b0);
    wait_idle(tag);
  endtask

  initial begin
    logic [5:0] w[8];
    logic [7:0] v_hold;
    int         idx, k, n_l0, n_rv, rv0, acc0, dens;
    logic       ready_now, saw_full, stable_v, stable_b, no_rv;

    rst = 1'b1; in_valid = 1'b0; in_data = 6'h00; tog = 1'b0;
    step();
    chk("rst_vector", vector, 8'h00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 6'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    step();

    // Directed loopback words
    send_one(6'b000001, 6'h15, "w01");
    send_one(6'b000011, 6'h00, "w03");
    send_one(6'b111111, 6'h00, "w3f");
    send_one(6'b000111, 6'h15, "w07");

    // Burst long enough to fill the FIFO while words drain at one per HOLD edges
    for (int i = 0; i < 8; i++) w[i] = 6'($urandom);
    n_l0 = launch_cyc_q.size();
    n_rv = rv_count;
    idx = 0; k = 0; saw_full = 1'b0;
    in_valid = 1'b1; in_data = w[0];
    while (idx < 8 && k < 60) begin
      ready_now = in_ready;
      step();
      k++;
      if (ready_now) idx++;
      if (fifo_count == DEPTH && !in_ready) saw_full = 1'b1;
      if (idx < 8) in_data = w[idx];
    end
    in_valid = 1'b0;
    chk("burst_accepted", idx, 8);
    chk("burst_full_seen", saw_full, 1'b1);
    k = 0;
    while (rv_count < n_rv + 8 && k < 100) begin
      step();
      k++;
    end
    chk("burst_results", rv_count - n_rv, 8);
    chk("burst_launches", launch_cyc_q.size() - n_l0, 8);
    if (launch_cyc_q.size() >= n_l0 + 8)
      chk("burst_spacing", launch_cyc_q[n_l0 + 7] - launch_cyc_q[n_l0], 7 * HOLD);
    wait_idle("burst");

    // Empty FIFO: bus frozen, no pulses
    v_hold = vector; n_rv = rv_count;
    stable_v = 1'b1; stable_b = 1'b1; no_rv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vector !== v_hold) stable_v = 1'b0;
      if (busy !== 1'b0) stable_b = 1'b0;
      if (res_valid !== 1'b0) no_rv = 1'b0;
    end
    chk("idle_vector", stable_v, 1'b1);
    chk("idle_busy", stable_b, 1'b1);
    chk("idle_no_rv", no_rv, 1'b1);
    chk("idle_rv_count", rv_count, n_rv);

    // Reset one cycle after a launch, with two words still queued
    step(); in_valid = 1'b1; in_data = 6'($urandom);
    step(); in_data = 6'($urandom);
    step(); in_data = 6'($urandom);
    step(); in_valid = 1'b0;
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_busy", busy, 1'b1);
    n_rv = rv_count;
    rst = 1'b1;
    #1;
    chk("mid_rst_vector", vector, 8'h00);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_res_data", res_data, 6'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", fifo_count, 0);
    step(); step();
    rst = 1'b0; tog = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_no_rv", rv_count, n_rv);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_busy", busy, 1'b0);
    send_one(6'b000111, 6'h15, "after_rst");

    // Random traffic with varying density
    rv0 = rv_count; acc0 = acc_total; dens = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(5, 95);
      in_valid = ($urandom_range(0, 99) < dens);
      in_data  = 6'($urandom);
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while ((acc_q.size() != 0 || fl_q.size() != 0 || busy) && k < 200) begin
      step();
      k++;
    end
    chk("rand_drain_acc", acc_q.size(), 0);
    chk("rand_drain_flight", fl_q.size(), 0);
    chk("rand_balance", rv_count - rv0, acc_total - acc0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
